// File: rtl/wptr_full_sync.sv
// Write-side pointer and status stage of a dual-clock FIFO. It synchronises the
// Gray read pointer into wclk and produces the write address, the Gray write pointer and the registered status.
module wptr_full_sync #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = (1 << ADDRSIZE) - 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  output logic                wclken,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_wq1_rptr;
  logic [PW-1:0] r_wq2_rptr;
  logic [PW-1:0] r_wlevel;
  logic          r_wfull;
  logic          r_walmost_full;
  logic          r_woverflow;

  logic [PW-1:0] w_wbinnext;
  logic [PW-1:0] w_wgraynext;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_diff;
  logic [PW-1:0] w_full_cmp;

  // Handshake: winc is the producer's request and wclken is the accept. A write
  // happens on an edge where wclken is high. wclken depends only on winc and the
  // registered wfull, so no combinational path from rptr to the accept exists.
  assign wclken       = winc & ~r_wfull;
  assign waddr        = r_wbin[ADDRSIZE-1:0];
  assign wptr         = r_wptr;
  assign wfull        = r_wfull;
  assign walmost_full = r_walmost_full;
  assign wlevel       = r_wlevel;
  assign woverflow    = r_woverflow;

  assign w_wbinnext  = r_wbin + PW'(wclken);
  assign w_wgraynext = (w_wbinnext >> 1) ^ w_wbinnext;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_rbin = '0;
    for (int i = 0; i < PW; i++) begin
      w_rbin[i] = ^(r_wq2_rptr >> i);
    end
  end

  assign w_diff     = w_wbinnext - w_rbin;
  assign w_full_cmp = {~r_wq2_rptr[PW-1:PW-2], r_wq2_rptr[PW-3:0]};

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_wbin         <= '0;
      r_wptr         <= '0;
      r_wq1_rptr     <= '0;
      r_wq2_rptr     <= '0;
      r_wlevel       <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_woverflow    <= 1'b0;
    end else begin
      r_wbin         <= w_wbinnext;
      r_wptr         <= w_wgraynext;
      r_wq1_rptr     <= rptr;
      r_wq2_rptr     <= r_wq1_rptr;
      r_wlevel       <= w_diff;
      r_wfull        <= (w_wgraynext == w_full_cmp);
      r_walmost_full <= (w_diff >= AF_T);
      r_woverflow    <= r_woverflow | (winc & r_wfull);
    end
  end

endmodule

// File: tb/tb_wptr_full_sync.sv
// Bench for wptr_full_sync: directed vectors with literal expectations plus a
// count-based model compared on every falling edge.
module tb_wptr_full_sync;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          wclk;
  logic          wrst_n;
  logic          winc;
  logic [AW:0]   rptr;
  logic          wclken;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wlevel;
  logic          woverflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  wptr_full_sync #(.ADDRSIZE(AW)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .rptr         (rptr),
    .wclken       (wclken),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  // clock / reset block
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [AW:0] to_gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] from_gray(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: count of accepted writes plus the read pointer as seen two edges late.
  logic [AW:0] m_cnt;
  logic [AW:0] m_seen1;
  logic [AW:0] m_seen2;
  logic [AW:0] m_level;
  logic        m_full;
  logic        m_afull;
  logic        m_ovf;
  logic        m_acc;
  logic [AW:0] m_cnt_next;
  logic [AW:0] m_level_next;

  assign m_acc        = winc & ~m_full;
  assign m_cnt_next   = m_cnt + {{AW{1'b0}}, m_acc};
  assign m_level_next = m_cnt_next - from_gray(m_seen2);

  always @(posedge wclk) begin
    if (!wrst_n) begin
      m_cnt   <= '0;
      m_seen1 <= '0;
      m_seen2 <= '0;
      m_level <= '0;
      m_full  <= 1'b0;
      m_afull <= 1'b0;
      m_ovf   <= 1'b0;
    end else begin
      m_cnt   <= m_cnt_next;
      m_seen1 <= rptr;
      m_seen2 <= m_seen1;
      m_level <= m_level_next;
      m_full  <= (m_level_next == (AW+1)'(DEPTH));
      m_afull <= (int'(m_level_next) >= DEPTH - 2);
      m_ovf   <= m_ovf | (winc & m_full);
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge wclk) begin
    if (chk_en) begin
      chk("cyc_wclken", 32'(wclken), 32'(m_acc));
      chk("cyc_waddr", 32'(waddr), 32'(m_cnt[AW-1:0]));
      chk("cyc_wptr", 32'(wptr), 32'(to_gray(m_cnt)));
      chk("cyc_wfull", 32'(wfull), 32'(m_full));
      chk("cyc_walmost_full", 32'(walmost_full), 32'(m_afull));
      chk("cyc_wlevel", 32'(wlevel), 32'(m_level));
      chk("cyc_woverflow", 32'(woverflow), 32'(m_ovf));
      chk("cyc_level_bound", 32'(int'(wlevel) <= DEPTH), 32'd1);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    step();
    wrst_n = 1'b1;
  endtask

  logic [AW:0] prev_wptr;
  bit          saw_addr_wrap;
  bit          saw_bin_wrap;
  int          nwr;

  initial begin
    wrst_n = 1'b0;
    winc   = 1'b1;
    rptr   = '0;

    // reset held two edges with winc high
    step();
    chk_en = 1'b1;
    step();
    chk("rst_wptr", 32'(wptr), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wfull", 32'(wfull), 32'd0);
    chk("rst_wlevel", 32'(wlevel), 32'd0);
    chk("rst_woverflow", 32'(woverflow), 32'd0);
    chk("rst_wclken_hi", 32'(wclken), 32'd1);
    winc = 1'b0;
    #1;
    chk("rst_wclken_lo", 32'(wclken), 32'd0);
    wrst_n = 1'b1;

    // fill sixteen entries with rptr held at zero
    for (int i = 0; i < DEPTH; i++) begin
      winc = 1'b1;
      #1;
      chk("fill_waddr", 32'(waddr), 32'(i));
      step();
      if (i == 12) chk("fill_afull_13", 32'(walmost_full), 32'd0);
      if (i == 13) chk("fill_afull_14", 32'(walmost_full), 32'd1);
      if (i == 14) chk("fill_full_15", 32'(wfull), 32'd0);
    end
    winc = 1'b0;
    chk("fill_wfull", 32'(wfull), 32'd1);
    chk("fill_wlevel", 32'(wlevel), 32'd16);
    chk("fill_wptr", 32'(wptr), 32'b11000);

    // write attempts while full are dropped and latch overflow
    for (int i = 0; i < 3; i++) begin
      winc = 1'b1;
      #1;
      chk("wwf_wclken", 32'(wclken), 32'd0);
      step();
      chk("wwf_waddr", 32'(waddr), 32'd0);
      chk("wwf_wptr", 32'(wptr), 32'b11000);
      chk("wwf_ovf", 32'(woverflow), 32'd1);
    end
    winc = 1'b0;
    step();
    chk("wwf_ovf_sticky", 32'(woverflow), 32'd1);

    // one read frees a slot; full drops on the third edge
    rptr = 5'b00001;
    step();
    chk("drain_full_k", 32'(wfull), 32'd1);
    step();
    chk("drain_full_k1", 32'(wfull), 32'd1);
    step();
    chk("drain_full_k2", 32'(wfull), 32'd0);
    chk("drain_level", 32'(wlevel), 32'd15);

    // wrap-around with a reader lagging three writes behind
    rptr = '0;
    do_reset();
    prev_wptr     = wptr;
    saw_addr_wrap = 1'b0;
    saw_bin_wrap  = 1'b0;
    nwr           = 0;
    for (int i = 0; i < 40; i++) begin
      winc = 1'b1;
      rptr = to_gray((AW+1)'((nwr >= 3) ? nwr - 3 : 0));
      #1;
      if (waddr == 4'd15) saw_addr_wrap = 1'b1;
      if (wptr == to_gray(5'd31)) saw_bin_wrap = 1'b1;
      step();
      nwr++;
      chk("wrap_gray_1bit", 32'($countones(wptr ^ prev_wptr)), 32'd1);
      chk("wrap_wfull", 32'(wfull), 32'd0);
      chk("wrap_ovf", 32'(woverflow), 32'd0);
      if (saw_addr_wrap && waddr == 4'd0) begin
        chk("wrap_waddr_15_0", 32'(waddr), 32'd0);
        saw_addr_wrap = 1'b0;
      end
      if (saw_bin_wrap) begin
        chk("wrap_wbin_31_0", 32'(wptr), 32'd0);
        saw_bin_wrap = 1'b0;
      end
      prev_wptr = wptr;
    end
    winc = 1'b0;
    chk("wrap_final_wptr", 32'(wptr), 32'(to_gray(5'd8)));

    // mid-operation reset at level seven
    rptr = '0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      winc = 1'b1;
      step();
    end
    chk("mid_level7", 32'(wlevel), 32'd7);
    wrst_n = 1'b0;
    winc   = 1'b1;
    step();
    chk("mid_wptr", 32'(wptr), 32'd0);
    chk("mid_waddr", 32'(waddr), 32'd0);
    chk("mid_wfull", 32'(wfull), 32'd0);
    chk("mid_afull", 32'(walmost_full), 32'd0);
    chk("mid_wlevel", 32'(wlevel), 32'd0);
    chk("mid_ovf", 32'(woverflow), 32'd0);
    wrst_n = 1'b1;
    #1;
    chk("mid_next_waddr", 32'(waddr), 32'd0);
    chk("mid_next_wclken", 32'(wclken), 32'd1);
    step();
    winc = 1'b0;
    chk("mid_after_waddr", 32'(waddr), 32'd1);
    chk("mid_after_level", 32'(wlevel), 32'd1);
    step();
    step();

    // final report
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
